// File: rtl/regfile_dump.sv
// Read-side scanner for the register bank: walks an address range on the asynchronous read port
// and streams every register out over valid/ready. Define REGFILE_DUMP_CHECKSUM_EN for a trailing XOR beat.
module regfile_dump #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, FIN} state_t;
    logic [DATA_W-1:0] xorAcc;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] curAddr;
    logic [ADDR_W-1:0] lastAddr;
    logic              isLast;

    assign isLast = (curAddr == lastAddr);

    // Single sequential FSM; every output is a register. rd_addr points at curAddr only
    // during LOAD, which is the cycle the bank word is captured into the beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            curAddr   <= '0;
            lastAddr  <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            xorAcc    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy    <= 1'b0;
                    rd_addr <= '0;
                    if (start) begin
                        curAddr  <= first_addr;
                        lastAddr <= last_addr;
                        busy     <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        xorAcc   <= '0;
`endif
                        if (first_addr > last_addr) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= FIN;
                            done  <= 1'b1;
`endif
                        end else begin
                            state   <= LOAD;
                            rd_addr <= first_addr;
                        end
                    end
                end
                LOAD: begin
                    out_data  <= rd_data;
                    out_addr  <= curAddr;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= isLast;
`endif
                    out_valid <= 1'b1;
                    rd_addr   <= '0;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        xorAcc    <= xorAcc ^ out_data;
`endif
                        if (isLast) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= FIN;
                            done  <= 1'b1;
`endif
                        end else begin
                            curAddr <= curAddr + 1'b1;
                            rd_addr <= curAddr + 1'b1;
                            state   <= LOAD;
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                // First CSUM cycle presents the accumulator; the beat is then held until accepted.
                CSUM: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= xorAcc;
                        out_addr  <= '0;
                        out_last  <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= FIN;
                        done      <= 1'b1;
                    end
                end
`endif
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: bank model, expected-beat queue built from a snapshot
// of the bank at start acceptance, and a per-cycle compare on the falling edge.
module tb_regfile_dump;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] bank [32];
    logic          wrEn = 1'b0;
    logic [AW-1:0] wrAddr = '0;
    logic [DW-1:0] wrData = '0;

    beat_t expQ[$];
    beat_t seenQ[$];
    beat_t sb;
    int    cyc = 0, validAt = -1, doneAt = -1;
    int    startCyc = -1, firstValidCyc = -1, doneCyc = -1, doneCount = 0;
    logic  mBusy = 1'b0, expValid, busyNow;
    int    checkCount = 0, passCount = 0;
    int    readyMode = 0;
    logic [DW-1:0] oldR7;

    regfile_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Bank: writes land on the rising edge, reads are asynchronous, register 0 reads as zero.
    always @(posedge clock) if (wrEn) bank[wrAddr] <= wrData;
    assign rd_data = (rd_addr == '0) ? '0 : bank[rd_addr];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic beat_t seenAt(input int i);
        if (i < seenQ.size()) return seenQ[i];
        return '0;
    endfunction

    // Expected dump = snapshot of the bank at acceptance, one beat per register in the range.
    function automatic void acceptDump(input logic [AW-1:0] f, input logic [AW-1:0] l);
        beat_t         b;
        logic [DW-1:0] x;
        x = '0;
        mBusy = 1'b1;
        startCyc = cyc;
        firstValidCyc = -1;
        for (int a = int'(f); a <= int'(l); a++) begin
            b.a = a[AW-1:0];
            b.d = (a == 0) ? '0 : bank[a];
            b.l = (CS == 0) && (a == int'(l));
            x = x ^ b.d;
            expQ.push_back(b);
        end
        if (CS != 0) begin
            b.a = '0;
            b.d = x;
            b.l = 1'b1;
            expQ.push_back(b);
        end
        if (expQ.size() == 0) doneAt = cyc + 1;
        else validAt = cyc + 2;
    endfunction

    // Per-cycle compare: a beat takes one LOAD cycle then is valid until accepted; done follows the final accept.
    initial forever begin
        @(negedge clock);
        cyc++;
        if (!reset_n) begin
            checkOutput("outputs in reset", {rd_addr, out_valid, out_data, out_addr, out_last, busy, done}, 64'd0);
            expQ.delete();
            mBusy = 1'b0;
            validAt = -1;
            doneAt = -1;
        end else begin
            expValid = (expQ.size() > 0) && (validAt >= 0) && (cyc >= validAt);
            checkOutput("out_valid", out_valid, expValid);
            checkOutput("busy", busy, mBusy);
            checkOutput("done", done, cyc == doneAt);
            if (!mBusy) checkOutput("rd_addr idle", rd_addr, 0);
            if (expQ.size() > 0 && cyc == validAt - 1) checkOutput("rd_addr load", rd_addr, expQ[0].a);
            if (expValid) begin
                checkOutput("out_addr", out_addr, expQ[0].a);
                checkOutput("out_data", out_data, expQ[0].d);
                checkOutput("out_last", out_last, expQ[0].l);
                if (firstValidCyc < 0) firstValidCyc = cyc;
            end
            if (done) begin
                doneCount++;
                doneCyc = cyc;
            end
            busyNow = mBusy;
            if (cyc == doneAt) mBusy = 1'b0;
            if (expValid && out_ready) begin
                sb.a = out_addr;
                sb.d = out_data;
                sb.l = out_last;
                seenQ.push_back(sb);
                void'(expQ.pop_front());
                if (expQ.size() == 0) begin
                    validAt = -1;
                    doneAt = cyc + 1;
                end else begin
                    validAt = cyc + 2;
                end
            end
            if (!busyNow && start) acceptDump(first_addr, last_addr);
        end
    end

    initial forever begin
        @(posedge clock);
        #2;
        if (readyMode == 1) out_ready = ~out_ready;
        else if (readyMode == 2) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic applyStimulus(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(posedge clock);
        #2;
        start = 1'b1;
        first_addr = f;
        last_addr = l;
        @(posedge clock);
        #2;
        start = 1'b0;
    endtask

    task automatic writeReg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clock);
        #2;
        wrEn = 1'b1;
        wrAddr = a;
        wrData = d;
    endtask

    task automatic endWrites();
        @(posedge clock);
        #2;
        wrEn = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((busy || mBusy) && n < budget) begin
            @(posedge clock);
            #3;
            n++;
        end
        checkOutput("dump finishes within budget", {62'd0, busy, mBusy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] f, l, t;
        logic [DW-1:0] v;
        int            n, bad;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            v = (i >= 1 && i <= 3) ? DW'(32'h11111111 * i) : DW'($urandom);
            if (i == 7) oldR7 = v;
            writeReg(AW'(i), v);
        end
        endWrites();

        $display("[TB] range 1..3, ready held high");
        out_ready = 1'b1;
        seenQ.delete();
        doneCount = 0;
        applyStimulus(5'd1, 5'd3);
        waitIdle(50);
        checkOutput("beat count 1..3", seenQ.size(), 3 + CS);
        checkOutput("beat r1", seenAt(0), {5'd1, 32'h11111111, 1'b0});
        checkOutput("beat r2", seenAt(1), {5'd2, 32'h22222222, 1'b0});
        checkOutput("beat r3", seenAt(2), {5'd3, 32'h33333333, 1'(CS == 0)});
        if (CS != 0) checkOutput("checksum beat", seenAt(3), {5'd0, 32'h00000000, 1'b1});
        checkOutput("done pulses 1..3", doneCount, 1);
        checkOutput("start to valid latency", firstValidCyc - startCyc, 2);

        $display("[TB] range 0..31, ready toggling");
        readyMode = 1;
        seenQ.delete();
        applyStimulus(5'd0, 5'd31);
        waitIdle(300);
        readyMode = 0;
        out_ready = 1'b1;
        checkOutput("beat count 0..31", seenQ.size(), 32 + CS);
        checkOutput("addr0 reads zero", seenAt(0).d, 0);
        bad = 0;
        for (int i = 0; i < 32; i++) if (seenAt(i).a != AW'(i)) bad++;
        checkOutput("beat order 0..31", bad, 0);
        checkOutput("last flag r31", seenAt(31).l, CS == 0);

        $display("[TB] empty range 5..4");
        seenQ.delete();
        doneCount = 0;
        applyStimulus(5'd5, 5'd4);
        waitIdle(20);
        checkOutput("empty range beats", seenQ.size(), CS);
        checkOutput("empty range done pulses", doneCount, 1);
        checkOutput("empty range done timing", doneCyc - startCyc, 1 + 2 * CS);
        checkOutput("empty range busy clear", busy, 0);

        $display("[TB] restart while busy and in FIN, write r7 during its load");
        seenQ.delete();
        doneCount = 0;
        applyStimulus(5'd5, 5'd9);
        applyStimulus(5'd0, 5'd31);
        n = 0;
        while (rd_addr != 5'd7 && n < 40) begin
            @(posedge clock);
            #2;
            n++;
        end
        checkOutput("r7 load reached", n < 40, 1);
        wrEn = 1'b1;
        wrAddr = 5'd7;
        wrData = ~oldR7;
        endWrites();
        n = 0;
        while (!done && n < 40) begin
            @(posedge clock);
            #2;
            n++;
        end
        checkOutput("done reached", n < 40, 1);
        start = 1'b1;
        first_addr = 5'd0;
        last_addr = 5'd31;
        @(posedge clock);
        #2;
        start = 1'b0;
        waitIdle(40);
        repeat (5) @(posedge clock);
        #3;
        checkOutput("ignored starts add no beats", seenQ.size(), 5 + CS);
        checkOutput("r7 snapshot value", seenAt(2), {5'd7, oldR7, 1'b0});
        checkOutput("single done after ignored starts", doneCount, 1);
        checkOutput("idle after ignored starts", busy, 0);

        $display("[TB] reset during a stalled beat");
        out_ready = 1'b0;
        applyStimulus(5'd10, 5'd20);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock);
            #2;
            n++;
        end
        checkOutput("stalled beat present", out_valid, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("async reset clears outputs",
                    {rd_addr, out_valid, out_data, out_addr, out_last, busy, done}, 64'd0);
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        out_ready = 1'b1;
        seenQ.delete();
        repeat (10) @(posedge clock);
        #3;
        checkOutput("no beats after reset", seenQ.size(), 0);
        checkOutput("busy low after reset", busy, 0);

        $display("[TB] randomized dumps");
        readyMode = 2;
        for (int k = 0; k < 25; k++) begin
            for (int j = 0; j < 4; j++) writeReg(AW'($urandom_range(1, 31)), DW'($urandom));
            endWrites();
            f = AW'($urandom_range(0, 31));
            l = AW'($urandom_range(0, 31));
            if (f > l && $urandom_range(0, 3) != 0) begin
                t = f;
                f = l;
                l = t;
            end
            applyStimulus(f, l);
            if ($urandom_range(0, 1) == 1) applyStimulus(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
            waitIdle(400);
        end
        readyMode = 0;
        repeat (3) @(posedge clock);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
